// File: rtl/rdx_pkg.sv
// Shared types and constants for the radix output path: lane count,
// legal radix factors and the packed vector record carried through the FIFO.
package rdx_pkg;

    localparam int RDX_W     = 18;
    localparam int NUM_LANES = 5;

    localparam logic [2:0] FCT2 = 3'd2;
    localparam logic [2:0] FCT3 = 3'd3;
    localparam logic [2:0] FCT4 = 3'd4;
    localparam logic [2:0] FCT5 = 3'd5;

    // One radix output vector: factor plus all five lanes, lane 0 first.
    typedef struct packed {
        logic [2:0]                            factor;
        logic [0:NUM_LANES-1][RDX_W-1:0]       re;
        logic [0:NUM_LANES-1][RDX_W-1:0]       im;
    } rdx_vec_t;

    // Only radix 2..5 exist in the datapath; anything else is a corrupt vector.
    function automatic logic is_legal_factor(input logic [2:0] f);
        return (f == FCT2) || (f == FCT3) || (f == FCT4) || (f == FCT5);
    endfunction

endpackage

// File: rtl/rdx_vec_fifo.sv
// Single-clock vector FIFO. The head is read combinationally from the
// storage array so the serializer can pick a lane in the same cycle.
// Callers must never push when full or pop when empty.
module rdx_vec_fifo
    import rdx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  rdx_vec_t                 wdata,
    input  logic                     pop,
    output rdx_vec_t                 head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    rdx_vec_t           mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q, level_d;

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers and level; pointers are AW bits wide and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/rdx_out_serializer.sv
// Buffers 5-lane radix output vectors and replays them one complex sample
// per cycle on a valid/ready stream, lanes 0..factor-1. Loss of a vector
// (FIFO full) or a corrupt factor is reported through sticky flags.
// wDataInOut must match the package lane width RDX_W.
module rdx_out_serializer
    import rdx_pkg::*;
#(
    parameter int wDataInOut = RDX_W,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    factor,
    input  logic                          in_val,
    input  logic signed [wDataInOut-1:0]  din_real [0:4],
    input  logic signed [wDataInOut-1:0]  din_imag [0:4],
    output logic                          in_rdy,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic signed [wDataInOut-1:0]  dout_real,
    output logic signed [wDataInOut-1:0]  dout_imag,
    output logic [2:0]                    out_lane,
    output logic                          out_sov,
    output logic                          out_eov,
    output logic                          ovf,
    output logic                          err_factor,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    rdx_vec_t            wr_vec, head;
    logic [LW-1:0]       fifo_level;
    logic                legal, push, pop, load, last_lane, fifo_empty;
    logic [wDataInOut-1:0] head_re, head_im;

    logic                rdy_en_q;
    logic [2:0]          lane_cnt_q;
    logic                out_val_q, out_sov_q, out_eov_q;
    logic [2:0]          out_lane_q;
    logic [wDataInOut-1:0] dout_re_q, dout_im_q;
    logic                ovf_q, err_factor_q;

    // Pack the incoming lanes into the FIFO record.
    assign wr_vec.factor = factor;
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pack
            assign wr_vec.re[gi] = din_real[gi];
            assign wr_vec.im[gi] = din_imag[gi];
        end
    endgenerate

    // in_rdy is held low until the first clock after reset release.
    assign in_rdy     = rdy_en_q & (fifo_level < FULL_LVL);
    assign legal      = is_legal_factor(factor);
    assign push       = in_val & in_rdy & legal;
    assign fifo_empty = (fifo_level == '0);
    assign load       = (!out_val_q || out_rdy) && !fifo_empty;
    assign last_lane  = (lane_cnt_q == head.factor - 3'd1);
    assign pop        = load & last_lane;

    rdx_vec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_vec),
        .pop   (pop),
        .head  (head),
        .level (fifo_level)
    );

    // Select the head lane addressed by the lane counter.
    always_comb begin
        head_re = head.re[0];
        head_im = head.im[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (lane_cnt_q == 3'(i)) begin
                head_re = head.re[i];
                head_im = head.im[i];
            end
        end
    end

    // Output register, lane counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q     <= 1'b0;
            lane_cnt_q   <= '0;
            out_val_q    <= 1'b0;
            out_sov_q    <= 1'b0;
            out_eov_q    <= 1'b0;
            out_lane_q   <= '0;
            dout_re_q    <= '0;
            dout_im_q    <= '0;
            ovf_q        <= 1'b0;
            err_factor_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (load) begin
                out_val_q  <= 1'b1;
                dout_re_q  <= head_re;
                dout_im_q  <= head_im;
                out_lane_q <= lane_cnt_q;
                out_sov_q  <= (lane_cnt_q == 3'd0);
                out_eov_q  <= last_lane;
                lane_cnt_q <= last_lane ? 3'd0 : lane_cnt_q + 3'd1;
            end else if (out_val_q && out_rdy) begin
                // Drained with nothing queued: drop valid, keep the data.
                out_val_q <= 1'b0;
            end
            if (in_val && !legal) err_factor_q <= 1'b1;
            if (in_val && legal && !in_rdy) ovf_q <= 1'b1;
        end
    end

    assign out_val    = out_val_q;
    assign dout_real  = dout_re_q;
    assign dout_imag  = dout_im_q;
    assign out_lane   = out_lane_q;
    assign out_sov    = out_sov_q;
    assign out_eov    = out_eov_q;
    assign ovf        = ovf_q;
    assign err_factor = err_factor_q;
    assign level      = fifo_level;

endmodule

// File: tb/tb_rdx_out_serializer.sv
// Directed bench for rdx_out_serializer: vector table plus hand sequences
// for backpressure, overflow, illegal factor and mid-drain reset.
module tb_rdx_out_serializer;
    import rdx_pkg::*;

    localparam int W     = 18;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [2:0]          factor;
    logic                in_val;
    logic signed [W-1:0] din_real [0:4];
    logic signed [W-1:0] din_imag [0:4];
    logic                in_rdy, out_val, out_rdy;
    logic [W-1:0]        dout_real, dout_imag;
    logic [2:0]          out_lane;
    logic                out_sov, out_eov, ovf, err_factor;
    logic [3:0]          level;

    always #5 clk = ~clk;

    rdx_out_serializer #(.wDataInOut(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .factor(factor), .in_val(in_val),
        .din_real(din_real), .din_imag(din_imag), .in_rdy(in_rdy),
        .out_val(out_val), .out_rdy(out_rdy), .dout_real(dout_real),
        .dout_imag(dout_imag), .out_lane(out_lane), .out_sov(out_sov),
        .out_eov(out_eov), .ovf(ovf), .err_factor(err_factor), .level(level)
    );

    // Input vector record with its expected sample count (0 = discarded).
    typedef struct {
        logic [2:0]            fct;
        logic [0:4][W-1:0]     re;
        logic [0:4][W-1:0]     im;
        int                    nsamp;
    } vec_t;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   lane;
        logic         sov;
        logic         eov;
    } smp_t;

    vec_t  tab [6];
    smp_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    sample_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for the next edge and queue its expected samples.
    task automatic drive_vec(input vec_t v);
        smp_t s;
        in_val = 1'b1;
        factor = v.fct;
        for (int l = 0; l < 5; l++) begin
            din_real[l] = v.re[l];
            din_imag[l] = v.im[l];
        end
        for (int l = 0; l < v.nsamp; l++) begin
            s.re   = v.re[l];
            s.im   = v.im[l];
            s.lane = 3'(l);
            s.sov  = (l == 0);
            s.eov  = (l == v.nsamp - 1);
            exp_q.push_back(s);
        end
    endtask

    function automatic vec_t mk_vec(input logic [2:0] f, input int base, input int nsamp);
        vec_t v;
        v.fct = f;
        for (int l = 0; l < 5; l++) begin
            v.re[l] = W'(base + l);
            v.im[l] = W'(-(base + l));
        end
        v.nsamp = nsamp;
        return v;
    endfunction

    // Stream monitor: scoreboard on each handshake, stability while stalled.
    logic        prev_stall = 1'b0;
    logic [41:0] held;
    always @(negedge clk) begin
        smp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if ({out_val, dout_real, dout_imag, out_lane, out_sov, out_eov} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h expected %0h",
                             {out_val, dout_real, dout_imag, out_lane, out_sov, out_eov}, held);
                end
            end
            if (out_val && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got lane %0d re %0h, expected none",
                             out_lane, dout_real);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_real, dout_imag, out_lane, out_sov, out_eov} !==
                        {e.re, e.im, e.lane, e.sov, e.eov}) begin
                        errors++;
                        $display("FAIL sample: got lane %0d re %0h im %0h sov %b eov %b, expected lane %0d re %0h im %0h sov %b eov %b",
                                 out_lane, dout_real, dout_imag, out_sov, out_eov,
                                 e.lane, e.re, e.im, e.sov, e.eov);
                    end
                    sample_cnt++;
                    $display("sample lane=%0d re=%0h im=%0h sov=%b eov=%b",
                             out_lane, dout_real, dout_imag, out_sov, out_eov);
                end
            end
            prev_stall = out_val && !out_rdy;
            held = {out_val, dout_real, dout_imag, out_lane, out_sov, out_eov};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    int total, gaps, base;
    logic seen, dropped;

    task automatic observe();
        if (out_val) begin
            total++;
            if (dropped) gaps++;
            seen = 1'b1;
        end else if (seen) begin
            dropped = 1'b1;
        end
    endtask

    initial begin
        vec_t v;
        in_val  = 1'b0;
        factor  = 3'd0;
        out_rdy = 1'b1;
        for (int l = 0; l < 5; l++) begin
            din_real[l] = '0;
            din_imag[l] = '0;
        end

        // Vector table: single f5, four back-to-back, one illegal.
        tab[0].fct = 3'd5;
        for (int l = 0; l < 5; l++) begin
            tab[0].re[l] = W'(l + 1);
            tab[0].im[l] = W'(-(l + 1));
        end
        tab[0].nsamp = 5;
        for (int i = 1; i <= 4; i++) begin
            tab[i] = mk_vec(3'(i + 1), 'h100 * i, i + 1);
        end
        tab[5] = mk_vec(3'd6, 'h600, 0);

        // Reset state
        repeat (2) tick();
        chk("rst_out_val", out_val, 0);
        chk("rst_level", level, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_data", {dout_real, dout_imag, out_lane, out_sov, out_eov}, 0);
        chk("rst_flags", {ovf, err_factor}, 0);
        rst_n = 1'b1;
        chk("in_rdy_before_clk", in_rdy, 0);
        tick();
        chk("in_rdy_after_clk", in_rdy, 1);

        // Single factor-5 vector: latency and length
        drive_vec(tab[0]);
        tick();
        in_val = 1'b0;
        chk("t1_no_early_val", out_val, 0);
        chk("t1_level_1", level, 1);
        tick();
        chk("t1_first_val", {out_val, out_lane, out_sov}, {1'b1, 3'd0, 1'b1});
        total = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_val) total++;
        end
        chk("t1_valid_cycles", total, 5);
        chk("t1_level_0", level, 0);

        // Back-to-back factors 2,3,4,5 with no gaps
        total = 0; gaps = 0; seen = 1'b0; dropped = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_vec(tab[i]);
            tick();
            observe();
        end
        in_val = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            observe();
        end
        chk("t2_total_samples", total, 14);
        chk("t2_gaps", gaps, 0);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Overflow: 9 pushes of factor 4 with the stream stalled
        out_rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t3_in_rdy_%0d", k), in_rdy, (k < 8) ? 1 : 0);
            drive_vec(mk_vec(3'd4, 'h1000 + 'h10 * k, (k < 8) ? 4 : 0));
            tick();
        end
        in_val = 1'b0;
        chk("t3_level_full", level, 8);
        chk("t3_in_rdy_low", in_rdy, 0);
        chk("t3_ovf_set", ovf, 1);
        base = sample_cnt;
        out_rdy = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (level == 0 && !out_val) break;
        end
        chk("t3_drained", sample_cnt - base, 32);
        chk("t3_ovf_sticky", ovf, 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Stall pattern 1,0,1,0 during a factor-3 vector
        out_rdy = 1'b0;
        drive_vec(mk_vec(3'd3, 'h3000, 3));
        tick();
        in_val = 1'b0;
        tick();
        chk("t4_lane0", {out_val, out_lane}, {1'b1, 3'd0});
        out_rdy = 1'b1; tick();
        out_rdy = 1'b0; tick();
        chk("t4_lane1_held", {out_val, out_lane}, {1'b1, 3'd1});
        out_rdy = 1'b1; tick();
        out_rdy = 1'b0; tick();
        chk("t4_lane2_held", {out_val, out_lane, out_eov}, {1'b1, 3'd2, 1'b1});
        out_rdy = 1'b1;
        repeat (3) tick();
        chk("t4_done", out_val, 0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Illegal factor 6
        drive_vec(tab[5]);
        tick();
        in_val = 1'b0;
        chk("t5_level", level, 0);
        chk("t5_err_factor", err_factor, 1);
        chk("t5_no_output", out_val, 0);
        repeat (5) tick();
        chk("t5_err_sticky", err_factor, 1);

        // Reset mid-drain: level 3, lane counter at 2
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_vec(mk_vec(3'd5, 'h5000 + 'h10 * i, 5));
            tick();
        end
        in_val = 1'b0;
        out_rdy = 1'b1; tick();
        out_rdy = 1'b0; tick();
        chk("t6_pre_level", level, 3);
        chk("t6_pre_lane", out_lane, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_out", {out_val, dout_real, dout_imag, out_lane, out_sov, out_eov}, 0);
        chk("t6_async_level_rdy", {level, in_rdy}, 0);
        chk("t6_flags_cleared", {ovf, err_factor}, 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        chk("t6_in_rdy_release", in_rdy, 0);
        tick();
        chk("t6_in_rdy_up", in_rdy, 1);
        out_rdy = 1'b1;
        drive_vec(mk_vec(3'd2, 'h7000, 2));
        tick();
        in_val = 1'b0;
        tick();
        chk("t6_new_lane0", {out_val, out_lane, out_sov}, {1'b1, 3'd0, 1'b1});
        repeat (4) tick();
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_level_0", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdx_out_serializer.md
Name: rdx_out_serializer

Overview:
- Downstream neighbour of the twiddle-multiply stage. Accepts one radix-output vector per cycle: 5 complex lanes plus its factor.
- Buffers vectors in a small FIFO and emits them one complex sample per cycle on a valid/ready stream, lanes 0..factor-1 in order.
- Feeds the stage-output memory writer.
- Absorbs the bursty 5-wide output of the radix datapath, which has no backpressure of its own, and flags any loss.

Parameters:
- wDataInOut, 18, width of each real/imag sample (signed)
- DEPTH, 8, FIFO depth in vectors; power of two, minimum 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- factor  in  3  radix of the incoming vector; legal values 2,3,4,5
- in_val  in  1  input vector valid
- din_real  in  wDataInOut x[0:4]  lane real parts, signed
- din_imag  in  wDataInOut x[0:4]  lane imag parts, signed
- in_rdy  out  1  FIFO can accept a vector this cycle
- out_val  out  1  output sample valid
- out_rdy  in  1  downstream accepts sample
- dout_real  out  wDataInOut  serial real sample, signed
- dout_imag  out  wDataInOut  serial imag sample, signed
- out_lane  out  3  lane index of current sample, 0..4
- out_sov  out  1  first sample of a vector (lane 0)
- out_eov  out  1  last sample of a vector (lane factor-1)
- ovf  out  1  sticky: vector arrived while full
- err_factor  out  1  sticky: illegal factor seen
- level  out  log2(DEPTH)+1  FIFO occupancy in vectors

Behaviour:
- Reset (async assert, sync release): every output is 0; FIFO empty; lane counter 0; sticky flags 0; in_rdy becomes 1 on the first clock after release.
- in_rdy = (level < DEPTH). It depends only on registered state. There is no same-cycle push-when-full bypass.
- Push rule: in_val & in_rdy & legal factor → vector {din_real, din_imag, factor} is written to the FIFO and level increments.
- in_val with factor in {0,1,6,7}: vector discarded, err_factor set.
- in_val & !in_rdy with legal factor: vector discarded, ovf set. Both sticky flags clear only on reset.
- Output register stage:
  - Loads when (!out_val | out_rdy) and the FIFO is non-empty.
  - Loads head lane[lane_cnt] into dout_real/dout_imag, lane_cnt into out_lane, sets out_val.
  - out_sov = (lane_cnt == 0); out_eov = (lane_cnt == head factor - 1).
  - When the loaded lane is the last one: pop the FIFO (level decrements) and lane_cnt → 0. Otherwise lane_cnt increments.
  - When the register empties (out_rdy & out_val) and the FIFO is empty: out_val → 0, and the data outputs hold their last value.
- Stream rule: while out_val & !out_rdy, all output fields hold stable.
- Latency: push at cycle N into an empty block gives out_val at N+1 with lane 0.
- Throughput: with out_rdy held at 1, one sample per cycle with no bubbles, including across vector boundaries.
- Simultaneous push and pop in one cycle: level unchanged. The pushed entry is never visible to the read side in the same cycle.
- Wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. Full is level == DEPTH.
- Arithmetic: none; data passes bit-exact and lanes ≥ factor are never emitted.

Decomposition:
- Shared package rdx_pkg:
  - NUM_LANES = 5
  - factor constants FCT2..FCT5
  - function is_legal_factor
  - typedef rdx_vec_t: packed {factor[2:0], real[0:4], imag[0:4]}, parameterised through wDataInOut by the package's width localparam
- One sub-module: rdx_vec_fifo.
  - Synchronous single-clock FIFO of rdx_vec_t with async active-low reset on pointers and level.
  - Combinational head output; push, pop, level ports.
- The top level holds the lane counter, output register and flags.

Test Plan:
- Single vector, factor 5, lanes real = 1,2,3,4,5 and imag = -1..-5, out_rdy = 1.
  - out_val for exactly 5 cycles starting at N+1, out_lane 0..4, correct data.
  - out_sov on lane 0, out_eov on lane 4; level returns to 0.
- Back-to-back vectors with factors 2,3,4,5 pushed on consecutive cycles, out_rdy = 1.
  - 14 contiguous valid samples with no gaps.
  - out_eov at lanes 1, 2, 3, 4 of the respective vectors; no lane ≥ factor emitted.
- out_rdy = 0 with 9 pushes of factor 4 (DEPTH = 8).
  - in_rdy drops after the 8th push (level = 8); the 9th is dropped and ovf = 1.
  - After out_rdy = 1: exactly 32 samples drain in order and ovf stays 1.
- out_rdy toggled 1,0,1,0 during a factor-3 vector.
  - Each sample is held stable while stalled; sequence is lanes 0,1,2 with no duplicates or skips.
- factor = 6 with in_val = 1.
  - Nothing written, level stays 0, err_factor = 1 and stays set until rst_n.
- rst_n asserted mid-drain with level = 3, lane_cnt = 2.
  - All outputs 0 immediately (async), flags cleared.
  - After release the first new vector starts at lane 0.
